// File: rtl/i2c_ctrl_pkg.sv
// Shared encodings for the I2C register-target controller and its bus timer.
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_PTR = 3'd1,
    ST_WR_IDLE = 3'd2,
    ST_BUS_WR  = 3'd3,
    ST_BUS_RD  = 3'd4,
    ST_TX_WAIT = 3'd5
  } ctrl_state_t;

  // Byte returned to the host when a read access is abandoned.
  localparam logic [7:0] BUS_RD_DEFAULT = 8'hFF;
  localparam logic [7:0] TX_RESET_VAL   = 8'hFF;

  function automatic logic addr_hit(input logic [7:0] addr_rw, input logic [6:0] target);
    return addr_rw[7:1] == target;
  endfunction

endpackage

// File: rtl/i2c_bus_timeout.sv
// Loadable down-counter guarding one outstanding bus access; expired stays high
// from the last permitted cycle until stop or a new start.
module i2c_bus_timeout #(
  parameter int CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic expired
);

  localparam int CW = $clog2(CYC);
  localparam logic [CW-1:0] LOAD = CW'(CYC - 1);

  logic [CW-1:0] cnt;
  logic          running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= LOAD;
      running <= 1'b1;
    end else if (stop) begin
      running <= 1'b0;
    end else if (running && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = running && (cnt == '0);

endmodule

// File: rtl/i2c_regfile_ctrl.sv
// Turns i2c_simple_slave strobes into register-bus accesses: first written byte
// is the pointer, later bytes are posted writes, reads are fetched under stall.
module i2c_regfile_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = 7'h42,
  parameter int         ADDR_W      = 8,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i2c_addr_rw,
  input  logic              i2c_addr_rw_valid_stb,
  input  logic [7:0]        i2c_data_rx,
  input  logic              i2c_data_rx_valid_stb,
  output logic [7:0]        i2c_data_tx,
  input  logic              i2c_data_tx_loaded_stb,
  input  logic              i2c_data_tx_done_stb,
  input  logic              i2c_error_stb,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] reg_ptr,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [2:0]        state_dbg
);

  // Bus handshake: bus_req rises with addr/we/wdata and holds them stable until
  // the cycle bus_ack is seen (or the timer expires); it is low the next cycle,
  // and bus_ack while bus_req is low is ignored. One access in flight at most.

  ctrl_state_t       state, state_nxt;
  logic              stall_nxt, req_nxt, we_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt, ptr_nxt;
  logic [7:0]        wdata_nxt, tx_nxt;

  // orphan: in-flight access whose result is no longer wanted.
  // issue_pend: FSM wants an access but an orphan still occupies the bus.
  logic              orphan, orphan_nxt;
  logic              issue_pend, pend_nxt, pend_we, pend_we_nxt;
  logic [7:0]        pend_data, pend_data_nxt;

  logic              tmo_expired, tmo_start, tmo_hit;
  logic              bus_done, own_done;
  logic              want_rd, want_wr;

  assign bus_done  = bus_req && (bus_ack || tmo_expired);
  assign own_done  = bus_done && !orphan;
  assign tmo_hit   = bus_req && tmo_expired && !bus_ack;
  assign state_dbg = state;

  i2c_bus_timeout #(
    .CYC (TIMEOUT_CYC)
  ) u_bus_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (tmo_start),
    .stop    (bus_done),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nxt     = state;
    stall_nxt     = stall;
    ptr_nxt       = reg_ptr;
    tx_nxt        = i2c_data_tx;
    req_nxt       = bus_req;
    we_nxt        = bus_we;
    addr_nxt      = bus_addr;
    wdata_nxt     = bus_wdata;
    err_nxt       = timeout_err;
    orphan_nxt    = orphan;
    pend_nxt      = issue_pend;
    pend_we_nxt   = pend_we;
    pend_data_nxt = pend_data;
    tmo_start     = 1'b0;
    want_rd       = 1'b0;
    want_wr       = 1'b0;

    if (bus_done) begin
      req_nxt    = 1'b0;
      orphan_nxt = 1'b0;
    end

    if (tmo_hit) err_nxt = 1'b1;
    else if (err_clr) err_nxt = 1'b0;

    if (i2c_error_stb || i2c_addr_rw_valid_stb) begin
      // Abandon whatever the FSM was doing; a live access finishes unobserved.
      stall_nxt = 1'b0;
      pend_nxt  = 1'b0;
      if (bus_req && !bus_done) orphan_nxt = 1'b1;
      if (i2c_error_stb || !addr_hit(i2c_addr_rw, I2C_ADDRESS)) state_nxt = ST_IDLE;
      else if (!i2c_addr_rw[0]) state_nxt = ST_GET_PTR;
      else want_rd = 1'b1;
    end else begin
      unique case (state)
        ST_GET_PTR: if (i2c_data_rx_valid_stb) begin
          ptr_nxt   = ADDR_W'(i2c_data_rx);
          state_nxt = ST_WR_IDLE;
        end
        ST_WR_IDLE: if (i2c_data_rx_valid_stb) want_wr = 1'b1;
        ST_BUS_WR: if (own_done) begin
          ptr_nxt   = reg_ptr + ADDR_W'(1);
          stall_nxt = 1'b0;
          state_nxt = ST_WR_IDLE;
        end
        ST_BUS_RD: if (own_done) begin
          tx_nxt    = bus_ack ? bus_rdata : BUS_RD_DEFAULT;
          stall_nxt = 1'b0;
          state_nxt = ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (i2c_data_tx_loaded_stb) ptr_nxt = reg_ptr + ADDR_W'(1);
          if (i2c_data_tx_done_stb) want_rd = 1'b1;
        end
        default: ;
      endcase
    end

    if (want_rd || want_wr) begin
      state_nxt = want_wr ? ST_BUS_WR : ST_BUS_RD;
      stall_nxt = 1'b1;
      if (!bus_req) begin
        req_nxt   = 1'b1;
        we_nxt    = want_wr;
        addr_nxt  = ptr_nxt;
        tmo_start = 1'b1;
        if (want_wr) wdata_nxt = i2c_data_rx;
      end else begin
        pend_nxt      = 1'b1;
        pend_we_nxt   = want_wr;
        pend_data_nxt = i2c_data_rx;
      end
    end else if (issue_pend && !bus_req) begin
      req_nxt   = 1'b1;
      we_nxt    = pend_we;
      addr_nxt  = reg_ptr;
      tmo_start = 1'b1;
      pend_nxt  = 1'b0;
      if (pend_we) wdata_nxt = pend_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      stall       <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      i2c_data_tx <= TX_RESET_VAL;
      reg_ptr     <= '0;
      timeout_err <= 1'b0;
      orphan      <= 1'b0;
      issue_pend  <= 1'b0;
      pend_we     <= 1'b0;
      pend_data   <= '0;
    end else begin
      state       <= state_nxt;
      stall       <= stall_nxt;
      bus_req     <= req_nxt;
      bus_we      <= we_nxt;
      bus_addr    <= addr_nxt;
      bus_wdata   <= wdata_nxt;
      i2c_data_tx <= tx_nxt;
      reg_ptr     <= ptr_nxt;
      timeout_err <= err_nxt;
      orphan      <= orphan_nxt;
      issue_pend  <= pend_nxt;
      pend_we     <= pend_we_nxt;
      pend_data   <= pend_data_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Bench for i2c_regfile_ctrl: strobe-level host driver, acking register-bus
// responder, and a queue of expected bus accesses.
module tb_i2c_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i2c_addr_rw = '0;
  logic        i2c_addr_rw_valid_stb = 1'b0;
  logic [7:0]  i2c_data_rx = '0;
  logic        i2c_data_rx_valid_stb = 1'b0;
  logic [7:0]  i2c_data_tx;
  logic        i2c_data_tx_loaded_stb = 1'b0;
  logic        i2c_data_tx_done_stb = 1'b0;
  logic        i2c_error_stb = 1'b0;
  logic        stall;
  logic        bus_req, bus_we;
  logic [7:0]  bus_addr, bus_wdata;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [7:0]  reg_ptr;
  logic        timeout_err;
  logic        err_clr = 1'b0;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  mem [256];
  int          ack_en = 1;
  int          ack_dly = 2;
  int          txn_cnt = 0;
  int          last_hi = 0;
  logic        stall_seen = 1'b0;

  i2c_regfile_ctrl #(
    .I2C_ADDRESS (7'h42),
    .ADDR_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb   (i2c_data_tx_done_stb),
    .i2c_error_stb          (i2c_error_stb),
    .stall                  (stall),
    .bus_req                (bus_req),
    .bus_we                 (bus_we),
    .bus_addr               (bus_addr),
    .bus_wdata              (bus_wdata),
    .bus_rdata              (bus_rdata),
    .bus_ack                (bus_ack),
    .reg_ptr                (reg_ptr),
    .timeout_err            (timeout_err),
    .err_clr                (err_clr),
    .state_dbg              (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_addr(input logic [7:0] b);
    @(negedge clk);
    i2c_addr_rw = b;
    i2c_addr_rw_valid_stb = 1'b1;
    @(negedge clk);
    i2c_addr_rw_valid_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    i2c_data_rx = b;
    i2c_data_rx_valid_stb = 1'b1;
    @(negedge clk);
    i2c_data_rx_valid_stb = 1'b0;
  endtask

  task automatic pulse_loaded();
    @(negedge clk);
    i2c_data_tx_loaded_stb = 1'b1;
    @(negedge clk);
    i2c_data_tx_loaded_stb = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    i2c_data_tx_done_stb = 1'b1;
    @(negedge clk);
    i2c_data_tx_done_stb = 1'b0;
  endtask

  task automatic pulse_err();
    @(negedge clk);
    i2c_error_stb = 1'b1;
    @(negedge clk);
    i2c_error_stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((stall || bus_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, "_settle_timeout"}, 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_q.push_back({1'b0, a, 8'h00});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (stall) stall_seen = 1'b1;
    end
  end

  // register-bus responder and scoreboard
  initial begin
    logic [16:0] obs, want;
    int hi;
    forever begin
      @(negedge clk);
      if (bus_req && !rst) begin
        txn_cnt++;
        obs = {bus_we, bus_addr, bus_we ? bus_wdata : 8'h00};
        if (exp_q.size() == 0) begin
          check("unexpected_bus_txn", 32'(obs), 32'h1FFFF);
        end else begin
          want = exp_q.pop_front();
          check("bus_txn", 32'(obs), 32'(want));
        end
        if (ack_en != 0) begin
          repeat (ack_dly) @(negedge clk);
          if (bus_req) check("bus_hold_stable", 32'({bus_we, bus_addr, bus_we ? bus_wdata : 8'h00}), 32'(obs));
          if (bus_we) mem[bus_addr] = bus_wdata;
          bus_rdata = mem[bus_addr];
          bus_ack = 1'b1;
          @(negedge clk);
          bus_ack = 1'b0;
          bus_rdata = '0;
          check("req_drop_after_ack", 32'(bus_req), 32'd0);
        end else begin
          hi = 0;
          while (bus_req && hi < 1000) begin
            hi++;
            @(negedge clk);
          end
          last_hi = hi;
        end
      end
    end
  end

  initial begin
    logic [7:0] d0, d1;
    int         base_txn;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));

    #1;
    check("rst_async_state", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_misc", 32'({bus_we, bus_addr, bus_wdata}), 32'd0);
    check("rst_data_tx", 32'(i2c_data_tx), 32'hFF);
    check("rst_reg_ptr", 32'(reg_ptr), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // write pointer 0x10 then two posted writes
    stall_seen = 1'b0;
    send_addr({7'h42, 1'b0}); wait_idle("wr_addr");
    send_rx(8'h10);           wait_idle("wr_ptr");
    check("wr_no_stall_on_addr_ptr", 32'(stall_seen), 32'd0);
    push_wr(8'h10, 8'hAA);
    send_rx(8'hAA);           wait_idle("wr_d0");
    check("wr_stall_on_data", 32'(stall_seen), 32'd1);
    push_wr(8'h11, 8'hBB);
    send_rx(8'hBB);           wait_idle("wr_d1");
    check("wr_reg_ptr", 32'(reg_ptr), 32'h12);

    // pointer write, repeated start, three reads (ack, ack, nak)
    send_addr({7'h42, 1'b0}); wait_idle("rd_addr_w");
    send_rx(8'h20);           wait_idle("rd_ptr");
    push_rd(8'h20);
    send_addr({7'h42, 1'b1}); wait_idle("rd_addr_r");
    check("rd_tx0", 32'(i2c_data_tx), 32'(mem[8'h20]));
    check("rd_ptr_not_moved", 32'(reg_ptr), 32'h20);
    for (int k = 1; k < 3; k++) begin
      pulse_loaded();
      push_rd(8'(8'h20 + k));
      pulse_done();           wait_idle("rd_next");
      check("rd_tx_next", 32'(i2c_data_tx), 32'(mem[8'(8'h20 + k)]));
    end
    check("rd_ptr_after_nak", 32'(reg_ptr), 32'h22);

    // foreign address: nothing may happen
    base_txn = txn_cnt;
    stall_seen = 1'b0;
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    send_addr({7'h43, 1'b0}); wait_idle("na_addr");
    check("na_state_idle", 32'(state_dbg), 32'd0);
    send_rx(d0);              wait_idle("na_d0");
    send_rx(d1);              wait_idle("na_d1");
    check("na_no_bus_txn", 32'(txn_cnt - base_txn), 32'd0);
    check("na_reg_ptr", 32'(reg_ptr), 32'h22);
    check("na_no_stall", 32'(stall_seen), 32'd0);

    // read with ack withheld -> timeout
    send_addr({7'h42, 1'b0}); wait_idle("to_addr_w");
    send_rx(8'h30);           wait_idle("to_ptr");
    ack_en = 0;
    push_rd(8'h30);
    send_addr({7'h42, 1'b1}); wait_idle("to_read");
    check("to_req_cycles", 32'(last_hi), 32'd16);
    check("to_tx_default", 32'(i2c_data_tx), 32'hFF);
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_ptr_kept", 32'(reg_ptr), 32'h30);
    ack_en = 1;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("to_err_cleared", 32'(timeout_err), 32'd0);

    // pointer wrap
    send_addr({7'h42, 1'b0}); wait_idle("wrap_addr");
    send_rx(8'hFF);           wait_idle("wrap_ptr");
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    push_wr(8'hFF, d0);
    send_rx(d0);              wait_idle("wrap_d0");
    push_wr(8'h00, d1);
    send_rx(d1);              wait_idle("wrap_d1");
    check("wrap_reg_ptr", 32'(reg_ptr), 32'h01);

    // protocol error while a write is outstanding
    ack_dly = 5;
    send_addr({7'h42, 1'b0}); wait_idle("err_addr");
    send_rx(8'h50);           wait_idle("err_ptr");
    push_wr(8'h50, 8'h77);
    send_rx(8'h77);
    check("err_stall_up", 32'(stall), 32'd1);
    pulse_err();
    check("err_stall_low", 32'(stall), 32'd0);
    check("err_state_idle", 32'(state_dbg), 32'd0);
    check("err_req_still_up", 32'(bus_req), 32'd1);
    wait_idle("err_orphan");
    check("err_ptr_unchanged", 32'(reg_ptr), 32'h50);

    // asynchronous reset in the middle of a request
    send_addr({7'h42, 1'b0}); wait_idle("rst_addr");
    send_rx(8'h60);           wait_idle("rst_ptr");
    push_wr(8'h60, 8'h99);
    send_rx(8'h99);
    #2 rst = 1'b1;
    #1;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_reg_ptr", 32'(reg_ptr), 32'd0);
    check("midrst_tx", 32'(i2c_data_tx), 32'hFF);
    check("midrst_bus_misc", 32'({bus_we, bus_addr, bus_wdata}), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
